// File: rtl/trig_lookup_arbiter.sv
// Round-robin sharing of one fixed-latency cos/sin ROM port among NUM_REQ requesters,
// with quadrant sign/range tagging and a credit-protected show-ahead result FIFO.
module trig_lookup_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int LOOKUP_LATENCY = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int ANGLE_MAX      = 360
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [16*NUM_REQ-1:0]      req_angle_in,
    output logic [NUM_REQ-1:0]         req_ready_out,
    output logic [8:0]                 lk_angle_out,
    input  logic [15:0]                lk_cos_abs_in,
    input  logic [15:0]                lk_sin_abs_in,
    output logic                       res_valid_out,
    input  logic                       res_ready_in,
    output logic [$clog2(NUM_REQ)-1:0] res_id_out,
    output logic [15:0]                res_cos_abs_out,
    output logic [15:0]                res_sin_abs_out,
    output logic                       res_cos_sign_out,
    output logic                       res_sin_sign_out,
    output logic                       res_err_out,
    output logic                       busy_out
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int SW  = $clog2(FIFO_DEPTH + LOOKUP_LATENCY + 1);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           cos_sign;
        logic           sin_sign;
        logic           err;
    } tag_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    cos_abs;
        logic [15:0]    sin_abs;
        logic           cos_sign;
        logic           sin_sign;
        logic           err;
    } res_t;

    logic [IDW-1:0] r_ptr;
    tag_t           r_tag [LOOKUP_LATENCY];
    res_t           r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    logic [15:0]    w_angles [NUM_REQ];
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;
    logic [IDW-1:0] w_gnt_idx;
    logic           w_found;
    logic [SW-1:0]  w_inflight;
    logic [SW-1:0]  w_occupancy;
    logic           w_credit;
    logic           w_grant;
    logic [15:0]    w_angle;
    logic           w_err;
    logic           w_cos_sign;
    logic           w_sin_sign;
    tag_t           w_tag_in;
    res_t           w_push_data;
    res_t           w_head;
    logic           w_push;
    logic           w_pop;
    logic           w_nonempty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_angles[i] = req_angle_in[16*i +: 16];
        end
    end

    // Round-robin search: first valid index at or after r_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path infers a latch.
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && req_valid_in[w_idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    // Credit counts only registered state, so a same-cycle pop never frees an issue slot.
    always_comb begin
        w_inflight = '0;
        for (int s = 0; s < LOOKUP_LATENCY; s++) begin
            w_inflight = w_inflight + SW'(r_tag[s].valid);
        end
        w_occupancy = w_inflight + SW'(r_count);
    end

    assign w_credit      = (w_occupancy < SW'(FIFO_DEPTH));
    assign w_grant       = w_found & w_credit & rst_n_in;
    assign req_ready_out = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;

    assign w_angle      = w_angles[w_gnt_idx];
    assign w_err        = (w_angle > 16'(ANGLE_MAX));
    assign w_cos_sign   = w_err | (w_angle < 16'd90) | (w_angle >= 16'd270);
    assign w_sin_sign   = w_err | (w_angle < 16'd180) | (w_angle == 16'd360);
    assign lk_angle_out = (w_grant && !w_err) ? w_angle[8:0] : 9'd0;

    always_comb begin
        w_tag_in          = '0;
        w_tag_in.valid    = w_grant;
        w_tag_in.id       = w_gnt_idx;
        w_tag_in.cos_sign = w_cos_sign;
        w_tag_in.sin_sign = w_sin_sign;
        w_tag_in.err      = w_err;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ptr <= '0;
            for (int s = 0; s < LOOKUP_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
            r_tag[0] <= w_tag_in;
            for (int s = 1; s < LOOKUP_LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            if (w_grant) begin
                r_ptr <= (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
            end
        end
    end

    // ROM data arrives aligned with the last tag stage and is pushed that same cycle.
    assign w_push     = r_tag[LOOKUP_LATENCY-1].valid;
    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty & res_ready_in;

    always_comb begin
        w_push_data          = '0;
        w_push_data.id       = r_tag[LOOKUP_LATENCY-1].id;
        w_push_data.cos_abs  = r_tag[LOOKUP_LATENCY-1].err ? 16'd0 : lk_cos_abs_in;
        w_push_data.sin_abs  = r_tag[LOOKUP_LATENCY-1].err ? 16'd0 : lk_sin_abs_in;
        w_push_data.cos_sign = r_tag[LOOKUP_LATENCY-1].cos_sign;
        w_push_data.sin_sign = r_tag[LOOKUP_LATENCY-1].sin_sign;
        w_push_data.err      = r_tag[LOOKUP_LATENCY-1].err;
    end

    // NOTE: storage has no reset; r_count alone decides validity, so stale entries stay hidden.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head = w_nonempty ? r_mem[r_rd_ptr] : '0;

    assign res_valid_out    = w_nonempty;
    assign res_id_out       = w_head.id;
    assign res_cos_abs_out  = w_head.cos_abs;
    assign res_sin_abs_out  = w_head.sin_abs;
    assign res_cos_sign_out = w_head.cos_sign;
    assign res_sin_sign_out = w_head.sin_sign;
    assign res_err_out      = w_head.err;
    assign busy_out         = (w_inflight != '0) | w_nonempty;

endmodule

// File: tb/tb_trig_lookup_arbiter.sv
// Directed self-checking bench for trig_lookup_arbiter with a 2-cycle ROM model
// (|cos| = 3a+1, |sin| = 5a+7 for ROM address a).
module tb_trig_lookup_arbiter;

    logic        clk_in;
    logic        rst_n_in;
    logic [3:0]  req_valid_in;
    logic [63:0] req_angle_in;
    logic [3:0]  req_ready_out;
    logic [8:0]  lk_angle_out;
    logic [15:0] lk_cos_abs_in;
    logic [15:0] lk_sin_abs_in;
    logic        res_valid_out;
    logic        res_ready_in;
    logic [1:0]  res_id_out;
    logic [15:0] res_cos_abs_out;
    logic [15:0] res_sin_abs_out;
    logic        res_cos_sign_out;
    logic        res_sin_sign_out;
    logic        res_err_out;
    logic        busy_out;

    int n_checks = 0;
    int n_errors = 0;

    trig_lookup_arbiter #(
        .NUM_REQ(4), .LOOKUP_LATENCY(2), .FIFO_DEPTH(4), .ANGLE_MAX(360)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_in(req_valid_in), .req_angle_in(req_angle_in),
        .req_ready_out(req_ready_out), .lk_angle_out(lk_angle_out),
        .lk_cos_abs_in(lk_cos_abs_in), .lk_sin_abs_in(lk_sin_abs_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
        .res_id_out(res_id_out), .res_cos_abs_out(res_cos_abs_out),
        .res_sin_abs_out(res_sin_abs_out), .res_cos_sign_out(res_cos_sign_out),
        .res_sin_sign_out(res_sin_sign_out), .res_err_out(res_err_out),
        .busy_out(busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [15:0] rom_cos(input logic [15:0] a);
        return a * 16'd3 + 16'd1;
    endfunction

    function automatic logic [15:0] rom_sin(input logic [15:0] a);
        return a * 16'd5 + 16'd7;
    endfunction

    logic [8:0] rom_a1, rom_a2;
    always @(posedge clk_in) begin
        rom_a1 <= lk_angle_out;
        rom_a2 <= rom_a1;
    end
    assign lk_cos_abs_in = rom_cos(16'(rom_a2));
    assign lk_sin_abs_in = rom_sin(16'(rom_a2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step to 2ns after the next rising edge; inputs are driven here, outputs checked 1ns later.
    task automatic cyc();
        @(posedge clk_in);
        #2;
    endtask

    task automatic set_angles(input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [15:0] a3);
        req_angle_in = {a3, a2, a1, a0};
    endtask

    logic [15:0] t4_ang [10] = '{16'd0, 16'd90, 16'd179, 16'd180, 16'd269,
                                 16'd270, 16'd359, 16'd360, 16'd361, 16'hFFFF};
    logic        t4_cs  [10] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    logic        t4_ss  [10] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    logic        t4_err [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    logic [8:0]  t4_lk  [10] = '{9'd0, 9'd90, 9'd179, 9'd180, 9'd269,
                                 9'd270, 9'd359, 9'd360, 9'd0, 9'd0};
    int          t3_id  [12] = '{0, 0, 0, 3, 3, 3, 3, 0, 1, 2, 3, 0};
    int          t3_rdy [12] = '{8, 1, 2, 4, 0, 0, 0, 8, 0, 0, 0, 0};

    int idx;
    logic [15:0] exp_ang;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_in     = 1'b0;
        req_valid_in = 4'h0;
        req_angle_in = '0;
        res_ready_in = 1'b0;

        // Reset state, including ready gated off while reset is held.
        #12;
        check("rst_res_valid", 32'(res_valid_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        req_valid_in = 4'hF;
        #1;
        check("rst_ready", 32'(req_ready_out), 32'd0);
        check("rst_lk_angle", 32'(lk_angle_out), 32'd0);
        req_valid_in = 4'h0;
        rst_n_in     = 1'b1;

        // Test 1: single request from requester 2, angle 45.
        cyc();
        req_valid_in = 4'b0100;
        set_angles(16'd0, 16'd0, 16'd45, 16'd0);
        #1;
        check("t1_ready", 32'(req_ready_out), 32'h4);
        check("t1_lk_angle", 32'(lk_angle_out), 32'd45);
        check("t1_c0_res_valid", 32'(res_valid_out), 32'd0);
        cyc();
        req_valid_in = 4'h0;
        #1;
        check("t1_c1_busy", 32'(busy_out), 32'd1);
        check("t1_c1_res_valid", 32'(res_valid_out), 32'd0);
        cyc();
        #1;
        check("t1_c2_res_valid", 32'(res_valid_out), 32'd0);
        cyc();
        #1;
        check("t1_c3_res_valid", 32'(res_valid_out), 32'd1);
        check("t1_id", 32'(res_id_out), 32'd2);
        check("t1_cos_abs", 32'(res_cos_abs_out), 32'd136);
        check("t1_sin_abs", 32'(res_sin_abs_out), 32'd232);
        check("t1_cos_sign", 32'(res_cos_sign_out), 32'd1);
        check("t1_sin_sign", 32'(res_sin_sign_out), 32'd1);
        check("t1_err", 32'(res_err_out), 32'd0);
        res_ready_in = 1'b1;
        cyc();
        #1;
        check("t1_c4_res_valid", 32'(res_valid_out), 32'd0);
        check("t1_c4_busy", 32'(busy_out), 32'd0);

        // Test 2: all valid, consumer always ready; pointer starts at 3 after test 1.
        set_angles(16'd10, 16'd20, 16'd30, 16'd40);
        for (int c = 0; c < 11; c++) begin
            cyc();
            req_valid_in = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                check("t2_ready", 32'(req_ready_out), 32'(4'b0001 << ((c + 3) % 4)));
            end
            if (c >= 3) begin
                idx = c % 4;
                check("t2_res_valid", 32'(res_valid_out), 32'd1);
                check("t2_id", 32'(res_id_out), 32'(idx));
                check("t2_cos_abs", 32'(res_cos_abs_out), 32'((10 * idx + 10) * 3 + 1));
            end
        end
        cyc();
        #1;
        check("t2_drain", 32'(res_valid_out), 32'd0);

        // Test 3: consumer stalled; credit caps grants at 4, a same-cycle pop frees nothing.
        res_ready_in = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            req_valid_in = (c <= 7) ? 4'hF : 4'h0;
            res_ready_in = (c >= 6);
            #1;
            check("t3_ready", 32'(req_ready_out), 32'(t3_rdy[c]));
            if (c >= 3 && c <= 10) begin
                check("t3_res_valid", 32'(res_valid_out), 32'd1);
                check("t3_id", 32'(res_id_out), 32'(t3_id[c]));
                check("t3_cos_abs", 32'(res_cos_abs_out), 32'((10 * t3_id[c] + 10) * 3 + 1));
            end
            if (c == 11) begin
                check("t3_drain", 32'(res_valid_out), 32'd0);
            end
        end

        // Test 4: quadrant edges and out-of-range angles from requester 0.
        res_ready_in = 1'b1;
        for (int c = 0; c < 13; c++) begin
            cyc();
            if (c < 10) begin
                req_valid_in = 4'b0001;
                set_angles(t4_ang[c], 16'd0, 16'd0, 16'd0);
            end else begin
                req_valid_in = 4'h0;
            end
            #1;
            if (c < 10) begin
                check("t4_ready", 32'(req_ready_out), 32'h1);
                check("t4_lk_angle", 32'(lk_angle_out), 32'(t4_lk[c]));
            end
            if (c >= 3) begin
                idx     = c - 3;
                exp_ang = t4_ang[idx];
                check("t4_res_valid", 32'(res_valid_out), 32'd1);
                check("t4_cos_sign", 32'(res_cos_sign_out), 32'(t4_cs[idx]));
                check("t4_sin_sign", 32'(res_sin_sign_out), 32'(t4_ss[idx]));
                check("t4_err", 32'(res_err_out), 32'(t4_err[idx]));
                check("t4_cos_abs", 32'(res_cos_abs_out),
                      t4_err[idx] ? 32'd0 : 32'(rom_cos(exp_ang)));
                check("t4_sin_abs", 32'(res_sin_abs_out),
                      t4_err[idx] ? 32'd0 : 32'(rom_sin(exp_ang)));
            end
        end
        cyc();
        #1;
        check("t4_drain", 32'(res_valid_out), 32'd0);
        check("t4_idle_busy", 32'(busy_out), 32'd0);

        // Test 5: reset with results in flight and buffered; pointer starts at 1.
        res_ready_in = 1'b0;
        set_angles(16'd10, 16'd20, 16'd30, 16'd40);
        for (int c = 0; c < 4; c++) begin
            cyc();
            req_valid_in = 4'hF;
            #1;
            check("t5_ready", 32'(req_ready_out), 32'(4'b0001 << ((c + 1) % 4)));
        end
        cyc();
        #1;
        check("t5_full_ready", 32'(req_ready_out), 32'd0);
        check("t5_full_busy", 32'(busy_out), 32'd1);
        check("t5_full_res_valid", 32'(res_valid_out), 32'd1);
        rst_n_in = 1'b0;
        #1;
        check("t5_rst_res_valid", 32'(res_valid_out), 32'd0);
        check("t5_rst_busy", 32'(busy_out), 32'd0);
        check("t5_rst_ready", 32'(req_ready_out), 32'd0);
        check("t5_rst_lk_angle", 32'(lk_angle_out), 32'd0);
        check("t5_rst_id", 32'(res_id_out), 32'd0);
        check("t5_rst_cos_abs", 32'(res_cos_abs_out), 32'd0);
        cyc();
        cyc();
        #1;
        check("t5_rst_hold_ready", 32'(req_ready_out), 32'd0);
        req_valid_in = 4'h0;
        rst_n_in     = 1'b1;
        cyc();
        req_valid_in = 4'hF;
        #1;
        check("t5_first_grant", 32'(req_ready_out), 32'h1);
        check("t5_first_lk", 32'(lk_angle_out), 32'd10);
        for (int c = 1; c < 5; c++) begin
            cyc();
            req_valid_in = 4'h0;
            #1;
            if (c == 3) begin
                check("t5_res_valid", 32'(res_valid_out), 32'd1);
                check("t5_id", 32'(res_id_out), 32'd0);
                check("t5_cos_abs", 32'(res_cos_abs_out), 32'd31);
                res_ready_in = 1'b1;
            end else begin
                check("t5_no_stale", 32'(res_valid_out), 32'd0);
            end
        end
        check("t5_idle_busy", 32'(busy_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
